// File: rtl/rv32i_types.sv
// Shared types for the pipeline control slice.
// Combinational definitions only; no latency.
// No flow control; consumed by the hazard controller and its helpers.
package rv32i_types;

    // Controller state; visible for debug only, outputs do not decode it
    // beyond suppressing load-use stalls while ID is being flushed.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FREEZE   = 2'd1,
        BUBBLE   = 2'd2,
        REDIRECT = 2'd3
    } pipe_state_t;

    // Per-stage register load enables, PC first.
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    localparam stage_en_t EN_ALL  = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
    localparam stage_en_t EN_NONE = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};

    // Enables for a load-use stall: hold PC and IF/ID, let the rest advance
    // so a bubble is inserted into ID/EX.
    function automatic stage_en_t en_stall_front();
        stage_en_t e;
        e       = EN_ALL;
        e.pc    = 1'b0;
        e.if_id = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
// Purely combinational, zero latency.
// No flow control; result is consumed the same cycle by the controller.
// Ports: ex_is_load_i/ex_rd_i describe EX; id_rs*_i/id_uses_rs*_i describe ID;
//        hazard_o is high when ID needs the load result that is not yet available.
module load_use_detect (
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
    assign rs2_match = id_uses_rs2_i && (ex_rd_i == id_rs2_i);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard_o  = ex_is_load_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline stall/flush controller with saturating performance counters.
// Latency: load enables are combinational; flushes are registered (one cycle after the cause).
// Backpressure: a pending memory access freezes every stage register until it completes.
// Ports: clk/rst (async active-high); imem_*/dmem_* memory handshakes; ex_br_taken
//        redirect; ex_*/id_* load-use operands; load_* stage enables; flush_* registered
//        clears; cnt_clr plus freeze/bubble/redirect counters (CNT_W bits, saturating).
module pipe_hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic             dmem_resp,
    input  logic             ex_br_taken,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    pipe_state_t      state_q, state_d;
    logic             flush_if_id_q, flush_if_id_d;
    logic             flush_id_ex_q, flush_id_ex_d;
    logic [CNT_W-1:0] freeze_cnt_q, bubble_cnt_q, redirect_cnt_q;

    stage_en_t        en;
    logic             mem_wait;
    logic             hazard_raw;
    logic             hazard;
    logic             inc_freeze;
    logic             inc_bubble;
    logic             inc_redirect;

    assign mem_wait = (imem_read && !imem_resp) ||
                      ((dmem_read || dmem_write) && !dmem_resp);

    load_use_detect u_load_use_detect (
        .ex_is_load_i  (ex_is_load),
        .ex_rd_i       (ex_rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .hazard_o      (hazard_raw)
    );

    // The instruction in ID during REDIRECT is the wrong-path one being
    // flushed, so its dependency must not stall the pipe.
    assign hazard = hazard_raw && (state_q != REDIRECT);

    always_comb begin
        state_d       = RUN;
        en            = EN_ALL;
        flush_if_id_d = 1'b0;
        flush_id_ex_d = 1'b0;
        inc_freeze    = 1'b0;
        inc_bubble    = 1'b0;
        inc_redirect  = 1'b0;

        if (mem_wait) begin
            // Nothing moves. A branch or hazard stays on the (stable) inputs
            // and is acted on once the access completes. No new flush is
            // issued, and any flush from the previous cycle has already
            // cleared its register, so the flush flops return low.
            state_d    = FREEZE;
            en         = EN_NONE;
            inc_freeze = 1'b1;
        end else if (ex_br_taken) begin
            state_d       = REDIRECT;
            flush_if_id_d = 1'b1;
            flush_id_ex_d = 1'b1;
            inc_redirect  = 1'b1;
        end else if (hazard) begin
            state_d       = BUBBLE;
            en            = en_stall_front();
            flush_id_ex_d = 1'b1;
            inc_bubble    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            flush_if_id_q <= 1'b1;
            flush_id_ex_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            flush_if_id_q <= flush_if_id_d;
            flush_id_ex_q <= flush_id_ex_d;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freeze_cnt_q   <= '0;
            bubble_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else if (cnt_clr) begin
            freeze_cnt_q   <= '0;
            bubble_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (inc_freeze)   freeze_cnt_q   <= sat_inc(freeze_cnt_q);
            if (inc_bubble)   bubble_cnt_q   <= sat_inc(bubble_cnt_q);
            if (inc_redirect) redirect_cnt_q <= sat_inc(redirect_cnt_q);
        end
    end

    // Enables are forced low for the whole reset window, not just at edges.
    assign load_pc      = en.pc     && !rst;
    assign load_if_id   = en.if_id  && !rst;
    assign load_id_ex   = en.id_ex  && !rst;
    assign load_ex_mem  = en.ex_mem && !rst;
    assign load_mem_wb  = en.mem_wb && !rst;

    assign flush_if_id  = flush_if_id_q;
    assign flush_id_ex  = flush_id_ex_q;

    assign freeze_cnt   = freeze_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             imem_read, imem_resp;
    logic             dmem_read, dmem_write, dmem_resp;
    logic             ex_br_taken;
    logic             ex_is_load;
    logic [4:0]       ex_rd, id_rs1, id_rs2;
    logic             id_uses_rs1, id_uses_rs2;
    logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             flush_if_id, flush_id_ex;
    logic             cnt_clr;
    logic [CNT_W-1:0] freeze_cnt, bubble_cnt, redirect_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_resp    (dmem_resp),
        .ex_br_taken  (ex_br_taken),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .cnt_clr      (cnt_clr),
        .freeze_cnt   (freeze_cnt),
        .bubble_cnt   (bubble_cnt),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] en_vec;
    logic [1:0] fl_vec;
    assign en_vec = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    assign fl_vec = {flush_if_id, flush_id_ex};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazard_inputs();
        ex_is_load  = 1'b0;
        ex_rd       = 5'd0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_read = 1'b0; imem_resp = 1'b0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
        ex_br_taken = 1'b0; cnt_clr = 1'b0;
        clear_hazard_inputs();

        // Reset held for three edges.
        repeat (3) tick();
        check("rst_flush", 32'(fl_vec), 32'b11);
        check("rst_en", 32'(en_vec), 32'b00000);
        check("rst_cnt", 32'({freeze_cnt, bubble_cnt, redirect_cnt}), 32'd0);

        rst = 1'b0;
        tick();
        check("post_rst_flush", 32'(fl_vec), 32'b00);
        check("post_rst_en", 32'(en_vec), 32'b11111);

        // Data-side miss for four cycles, completing on the fifth.
        dmem_read = 1'b1; dmem_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("dmiss_en", 32'(en_vec), 32'b00000);
            tick();
        end
        dmem_resp = 1'b1;
        #1 check("dresp_en", 32'(en_vec), 32'b11111);
        tick();
        dmem_read = 1'b0; dmem_resp = 1'b0;
        check("dmiss_freeze_cnt", 32'(freeze_cnt), 32'd4);
        check("dmiss_flush", 32'(fl_vec), 32'b00);

        // Loads to x0 and matches on unused sources are not hazards.
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1 check("x0_no_hazard", 32'(en_vec), 32'b11111);
        ex_rd = 5'd7; id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1 check("unused_rs2_no_hazard", 32'(en_vec), 32'b11111);

        // Load-use on rs2.
        ex_rd = 5'd5; id_rs1 = 5'd0; id_uses_rs1 = 1'b0; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1 check("hazard_en", 32'(en_vec), 32'b00111);
        tick();
        clear_hazard_inputs();
        check("bubble_flush", 32'(fl_vec), 32'b01);
        check("bubble_cnt", 32'(bubble_cnt), 32'd1);
        #1 check("bubble_after_en", 32'(en_vec), 32'b11111);
        tick();
        check("bubble_flush_one_cycle", 32'(fl_vec), 32'b00);

        // Branch with a simultaneous hazard: redirect wins.
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        ex_br_taken = 1'b1;
        #1 check("br_hz_en", 32'(en_vec), 32'b11111);
        tick();
        ex_br_taken = 1'b0;
        check("redirect_flush", 32'(fl_vec), 32'b11);
        check("redirect_bubble_cnt", 32'(bubble_cnt), 32'd1);
        check("redirect_cnt", 32'(redirect_cnt), 32'd1);
        // Hazard still present while in REDIRECT is ignored.
        #1 check("redirect_hazard_ignored", 32'(en_vec), 32'b11111);
        tick();
        clear_hazard_inputs();
        check("redirect_flush_one_cycle", 32'(fl_vec), 32'b00);
        check("redirect_no_bubble", 32'(bubble_cnt), 32'd1);

        // Branch held during a three-cycle instruction miss.
        imem_read = 1'b1; imem_resp = 1'b0; ex_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("imiss_en", 32'(en_vec), 32'b00000);
            tick();
            check("imiss_no_flush", 32'(fl_vec), 32'b00);
        end
        imem_resp = 1'b1;
        #1 check("iresp_en", 32'(en_vec), 32'b11111);
        tick();
        imem_read = 1'b0; imem_resp = 1'b0; ex_br_taken = 1'b0;
        check("imiss_redirect_flush", 32'(fl_vec), 32'b11);
        check("imiss_redirect_cnt", 32'(redirect_cnt), 32'd2);
        check("imiss_freeze_cnt", 32'(freeze_cnt), 32'd7);
        tick();
        check("imiss_flush_one_cycle", 32'(fl_vec), 32'b00);

        // Reset in the middle of a freeze with a branch pending.
        dmem_write = 1'b1; dmem_resp = 1'b0; ex_br_taken = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_flush", 32'(fl_vec), 32'b11);
        check("midrst_en", 32'(en_vec), 32'b00000);
        check("midrst_cnt", 32'({freeze_cnt, bubble_cnt, redirect_cnt}), 32'd0);
        dmem_write = 1'b0; ex_br_taken = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_release_flush", 32'(fl_vec), 32'b00);
        check("midrst_release_en", 32'(en_vec), 32'b11111);
        check("midrst_no_redirect", 32'(redirect_cnt), 32'd0);

        // Saturation and clear priority.
        dmem_read = 1'b1; dmem_resp = 1'b0;
        repeat (255) tick();
        check("sat_reach_max", 32'(freeze_cnt), 32'hFF);
        tick();
        check("sat_hold_max", 32'(freeze_cnt), 32'hFF);
        cnt_clr = 1'b1;
        tick();
        check("clr_beats_inc", 32'(freeze_cnt), 32'd0);
        cnt_clr = 1'b0;
        tick();
        check("count_after_clr", 32'(freeze_cnt), 32'd1);
        dmem_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
